uart_tx_fifo: RTL

Parametrised UART transmitter with an input FIFO, runtime-selectable parity and stop-bit count, and a valid/ready byte interface. It sits between the TDC result formatter and the serial pin. An external baud-rate tick (`enable`) paces it, and `OVERSAMPLE` ticks make one bit period. It replaces the fixed 8N1, edge-triggered transmitter: input is level handshaked, several bytes are buffered, and data width and framing are configurable.

---
 rtl/uart_tx_fifo.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO.
// Frames are start / DATA_BITS data (LSB first) / optional parity / one or two stop bits.
// Bit timing is derived from an external oversample tick: OVERSAMPLE ticks per bit period.
// Parity mode and stop-bit count are sampled when a word leaves the FIFO, so they hold
// for the whole frame.

module uart_tx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    input  logic                          din_valid,
    input  logic [DATA_BITS-1:0]          din_byte,
    output logic                          din_ready,
    output logic                          ser_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned SampW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head_word;

    // Transmit engine
    logic [2:0]           state_q, state_d;
    logic [SampW-1:0]     samp_q, samp_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_en_q, par_en_d;
    logic                 stop2_q, stop2_d;
    logic                 ser_q, ser_d;
    logic                 tick;

    assign full      = (count_q == CntW'(FIFO_DEPTH));
    assign push      = din_valid && !full;
    // The engine only takes a new word while idle.
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign head_word = mem_q[rd_ptr_q];

    // End of a bit period: last oversample tick of the current bit.
    assign tick = enable && (samp_q == SampW'(OVERSAMPLE - 1));

    assign din_ready  = !full;
    assign fifo_count = count_q;
    assign ser_out    = ser_q;
    assign tx_busy    = (state_q != StIdle);

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din_byte;
        end
    end

    // Frame sequencing: next state, bit counters and serial line level
    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        ser_d     = ser_q;

        if ((state_q != StIdle) && enable) begin
            samp_d = tick ? '0 : samp_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                ser_d = 1'b1;
                if (pop) begin
                    shift_d   = head_word;
                    // Parity comes from the whole popped word, not the shifting copy.
                    par_bit_d = (^head_word) ^ (parity_mode == 2'b10);
                    par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    stop2_d   = stop2;
                    samp_d    = '0;
                    bit_d     = '0;
                    state_d   = StStart;
                    ser_d     = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                    ser_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_q == BitW'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = StParity;
                            ser_d   = par_bit_q;
                        end else begin
                            state_d = StStop;
                            ser_d   = 1'b1;
                        end
                    end else begin
                        ser_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                    ser_d   = 1'b1;
                    bit_d   = '0;
                end
            end
            StStop: begin
                if (tick) begin
                    ser_d = 1'b1;
                    // bit_q counts completed stop periods.
                    if (stop2_q && (bit_q == '0)) begin
                        bit_d = BitW'(1);
                    end else begin
                        state_d = StIdle;
                        bit_d   = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                ser_d   = 1'b1;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset also flushes the FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= StIdle;
            samp_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            ser_q     <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            ser_q     <= ser_d;
        end
    end

endmodule
